// File: rtl/prga_check.sv
// RC4 pseudo-random generation and decrypt stage with a printable-ASCII check
// on every plaintext byte; reads S and ciphertext, writes length-prefixed plaintext.
module prga_check #(
  parameter bit         EARLY_ABORT = 1'b1,
  parameter logic [7:0] LO_CHAR     = 8'h20,
  parameter logic [7:0] HI_CHAR     = 8'h7E
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       rdy,
  output logic       valid,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
);

  localparam int unsigned DW = 8;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_RD_LEN  = 4'd1;
  localparam logic [3:0] S_GET_LEN = 4'd2;
  localparam logic [3:0] S_WR_LEN  = 4'd3;
  localparam logic [3:0] S_RD_SI   = 4'd4;
  localparam logic [3:0] S_GET_SI  = 4'd5;
  localparam logic [3:0] S_RD_SJ   = 4'd6;
  localparam logic [3:0] S_GET_SJ  = 4'd7;
  localparam logic [3:0] S_WR_SI   = 4'd8;
  localparam logic [3:0] S_WR_SJ   = 4'd9;
  localparam logic [3:0] S_RD_PAD  = 4'd10;
  localparam logic [3:0] S_GET_PAD = 4'd11;
  localparam logic [3:0] S_WR_PT   = 4'd12;
  localparam logic [3:0] S_DONE    = 4'd13;

  logic [3:0]    state, state_n;
  logic [DW-1:0] i, i_n, j, j_n, k, k_n, len, len_n, si, si_n, sj, sj_n;
  logic          rdy_n, valid_n, s_wren_n, pt_wren_n;
  logic [DW-1:0] s_addr_n, s_wrdata_n, ct_addr_n, pt_addr_n, pt_wrdata_n;
  logic          bad_c;

  // Byte currently being written to pt_mem falls outside the printable window
  assign bad_c = (pt_wrdata < LO_CHAR) || (pt_wrdata > HI_CHAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      len       <= '0;
      si        <= '0;
      sj        <= '0;
      rdy       <= 1'b1;
      valid     <= 1'b1;
      s_addr    <= '0;
      s_wrdata  <= '0;
      s_wren    <= 1'b0;
      ct_addr   <= '0;
      pt_addr   <= '0;
      pt_wrdata <= '0;
      pt_wren   <= 1'b0;
    end else begin
      state     <= state_n;
      i         <= i_n;
      j         <= j_n;
      k         <= k_n;
      len       <= len_n;
      si        <= si_n;
      sj        <= sj_n;
      rdy       <= rdy_n;
      valid     <= valid_n;
      s_addr    <= s_addr_n;
      s_wrdata  <= s_wrdata_n;
      s_wren    <= s_wren_n;
      ct_addr   <= ct_addr_n;
      pt_addr   <= pt_addr_n;
      pt_wrdata <= pt_wrdata_n;
      pt_wren   <= pt_wren_n;
    end
  end

  // Outputs are computed for the state being entered, so every port is a flop
  always_comb begin
    state_n     = state;
    i_n         = i;
    j_n         = j;
    k_n         = k;
    len_n       = len;
    si_n        = si;
    sj_n        = sj;
    rdy_n       = rdy;
    valid_n     = valid;
    s_addr_n    = s_addr;
    s_wrdata_n  = s_wrdata;
    s_wren_n    = 1'b0;
    ct_addr_n   = ct_addr;
    pt_addr_n   = pt_addr;
    pt_wrdata_n = pt_wrdata;
    pt_wren_n   = 1'b0;
    case (state)
      S_IDLE: begin
        if (en && rdy) begin
          state_n   = S_RD_LEN;
          rdy_n     = 1'b0;
          valid_n   = 1'b1;
          i_n       = '0;
          j_n       = '0;
          ct_addr_n = '0;
        end
      end
      S_RD_LEN:  state_n = S_GET_LEN;
      S_GET_LEN: begin
        state_n     = S_WR_LEN;
        len_n       = ct_rddata;
        pt_addr_n   = '0;
        pt_wrdata_n = ct_rddata;
        pt_wren_n   = 1'b1;
        k_n         = DW'(1);
      end
      S_WR_LEN: begin
        if (len == '0) begin
          state_n = S_DONE;
        end else begin
          state_n  = S_RD_SI;
          i_n      = DW'(i + DW'(1));
          s_addr_n = DW'(i + DW'(1));
        end
      end
      S_RD_SI:  state_n = S_GET_SI;
      S_GET_SI: begin
        state_n  = S_RD_SJ;
        si_n     = s_rddata;
        j_n      = DW'(j + s_rddata);
        s_addr_n = DW'(j + s_rddata);
      end
      S_RD_SJ:  state_n = S_GET_SJ;
      S_GET_SJ: begin
        state_n    = S_WR_SI;
        sj_n       = s_rddata;
        s_addr_n   = i;
        s_wrdata_n = s_rddata;
        s_wren_n   = 1'b1;
      end
      S_WR_SI: begin
        state_n    = S_WR_SJ;
        s_addr_n   = j;
        s_wrdata_n = si;
        s_wren_n   = 1'b1;
      end
      S_WR_SJ: begin
        state_n   = S_RD_PAD;
        s_addr_n  = DW'(si + sj);
        ct_addr_n = k;
      end
      S_RD_PAD:  state_n = S_GET_PAD;
      S_GET_PAD: begin
        state_n     = S_WR_PT;
        pt_addr_n   = k;
        pt_wrdata_n = s_rddata ^ ct_rddata;
        pt_wren_n   = 1'b1;
      end
      S_WR_PT: begin
        if (bad_c) valid_n = 1'b0;
        if ((bad_c && EARLY_ABORT) || (k == len)) begin
          state_n = S_DONE;
        end else begin
          state_n  = S_RD_SI;
          k_n      = DW'(k + DW'(1));
          i_n      = DW'(i + DW'(1));
          s_addr_n = DW'(i + DW'(1));
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        rdy_n   = 1'b1;
      end
      default: begin
        state_n = S_IDLE;
        rdy_n   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_prga_check.sv
// Scoreboard bench for prga_check: directed runs push expected pt writes and
// completion records; a negedge monitor pops and compares as the DUTs respond.
module tb_prga_check;

  typedef struct {
    int         inst;
    logic [7:0] addr;
    logic [7:0] data;
  } pt_exp_t;

  typedef struct {
    int   inst;
    logic v;
    int   lat;
  } done_exp_t;

  logic       clk;
  logic       rst;
  logic       en        [2];
  logic       rdy       [2];
  logic       valid     [2];
  logic [7:0] s_addr    [2];
  logic [7:0] s_rddata  [2];
  logic [7:0] s_wrdata  [2];
  logic       s_wren    [2];
  logic [7:0] ct_addr   [2];
  logic [7:0] ct_rddata [2];
  logic [7:0] pt_addr   [2];
  logic [7:0] pt_wrdata [2];
  logic       pt_wren   [2];

  logic [7:0] smem  [2][256];
  logic [7:0] ctmem [2][256];
  logic       init_req;

  pt_exp_t   exp_pt[$];
  done_exp_t exp_done[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int e0 [2];
  logic prev_rdy [2];

  prga_check #(.EARLY_ABORT(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en[0]), .rdy(rdy[0]), .valid(valid[0]),
    .s_addr(s_addr[0]), .s_rddata(s_rddata[0]), .s_wrdata(s_wrdata[0]), .s_wren(s_wren[0]),
    .ct_addr(ct_addr[0]), .ct_rddata(ct_rddata[0]),
    .pt_addr(pt_addr[0]), .pt_wrdata(pt_wrdata[0]), .pt_wren(pt_wren[0])
  );

  prga_check #(.EARLY_ABORT(1'b0)) dut_full (
    .clk(clk), .rst(rst), .en(en[1]), .rdy(rdy[1]), .valid(valid[1]),
    .s_addr(s_addr[1]), .s_rddata(s_rddata[1]), .s_wrdata(s_wrdata[1]), .s_wren(s_wren[1]),
    .ct_addr(ct_addr[1]), .ct_rddata(ct_rddata[1]),
    .pt_addr(pt_addr[1]), .pt_wrdata(pt_wrdata[1]), .pt_wren(pt_wren[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-address memories; init_req reloads S with the identity permutation
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int n = 0; n < 2; n++) begin
      s_rddata[n]  <= smem[n][s_addr[n]];
      ct_rddata[n] <= ctmem[n][ct_addr[n]];
      if (init_req) begin
        for (int a = 0; a < 256; a++) smem[n][a] <= 8'(a);
      end else if (s_wren[n]) begin
        smem[n][s_addr[n]] <= s_wrdata[n];
      end
      if (rdy[n] && en[n]) e0[n] <= cyc;
    end
  end

  // Monitor: pt writes, write-enable exclusivity, completion on rdy rise
  always @(negedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (!rst) begin
        if (pt_wren[n]) begin
          checks++;
          if (exp_pt.size() == 0) begin
            errors++;
            $display("FAIL pt_write inst%0d: got unexpected write addr %0h data %0h", n, pt_addr[n], pt_wrdata[n]);
          end else begin
            pt_exp_t e;
            e = exp_pt.pop_front();
            if (e.inst != n || e.addr != pt_addr[n] || e.data != pt_wrdata[n]) begin
              errors++;
              $display("FAIL pt_write inst%0d: got addr %0h data %0h, expected inst%0d addr %0h data %0h",
                       n, pt_addr[n], pt_wrdata[n], e.inst, e.addr, e.data);
            end
          end
        end
        if (pt_wren[n] || s_wren[n]) begin
          checks++;
          if (pt_wren[n] && s_wren[n]) begin
            errors++;
            $display("FAIL wren_onehot inst%0d: got s_wren=1 pt_wren=1, expected only one", n);
          end
        end
        if (rdy[n] && !prev_rdy[n]) begin
          checks++;
          if (exp_done.size() == 0) begin
            errors++;
            $display("FAIL done inst%0d: got unexpected completion", n);
          end else begin
            done_exp_t d;
            d = exp_done.pop_front();
            if (d.inst != n || d.v != valid[n] || d.lat != (cyc - 1 - e0[n])) begin
              errors++;
              $display("FAIL done inst%0d: got valid=%0b latency=%0d, expected inst%0d valid=%0b latency=%0d",
                       n, valid[n], cyc - 1 - e0[n], d.inst, d.v, d.lat);
            end
          end
        end
      end
      prev_rdy[n] = rdy[n];
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic exp_w(input int n, input logic [7:0] a, input logic [7:0] d);
    pt_exp_t e;
    e.inst = n; e.addr = a; e.data = d;
    exp_pt.push_back(e);
  endtask

  task automatic exp_end(input int n, input logic v, input int lat);
    done_exp_t d;
    d.inst = n; d.v = v; d.lat = lat;
    exp_done.push_back(d);
  endtask

  task automatic init_s();
    @(negedge clk); init_req = 1'b1;
    @(negedge clk); init_req = 1'b0;
  endtask

  task automatic set_ct(input int n, input logic [7:0] l, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3);
    ctmem[n][0] = l; ctmem[n][1] = b1; ctmem[n][2] = b2; ctmem[n][3] = b3;
  endtask

  task automatic start(input int n);
    @(negedge clk); en[n] = 1'b1;
    @(posedge clk); #1; en[n] = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (exp_done.size() != 0 && t < 300) begin
      @(negedge clk); t++;
    end
    checks++;
    if (exp_done.size() != 0) begin
      errors++;
      $display("FAIL wait_done: got %0d completions outstanding after timeout, expected 0", exp_done.size());
      exp_done.delete();
    end
    chk("pt_queue_drained", exp_pt.size(), 0);
    exp_pt.delete();
  endtask

  task automatic push_basic(input int n);
    exp_w(n, 8'd0, 8'd3); exp_w(n, 8'd1, 8'h41); exp_w(n, 8'd2, 8'h42); exp_w(n, 8'd3, 8'h43);
    exp_end(n, 1'b1, 31);
  endtask

  initial begin
    int t;
    rst = 1'b1; init_req = 1'b0;
    en[0] = 1'b0; en[1] = 1'b0;
    prev_rdy[0] = 1'b1; prev_rdy[1] = 1'b1;
    for (int n = 0; n < 2; n++)
      for (int a = 0; a < 256; a++) ctmem[n][a] = 8'h00;
    init_s();
    @(negedge clk); rst = 1'b0;

    // Reset state
    chk("reset_rdy", int'(rdy[0]), 1);
    chk("reset_valid", int'(valid[0]), 1);
    chk("reset_s_wren", int'(s_wren[0]), 0);
    chk("reset_pt_wren", int'(pt_wren[0]), 0);
    chk("reset_s_addr", int'(s_addr[0]), 0);
    chk("reset_pt_wrdata", int'(pt_wrdata[0]), 0);

    // Basic decrypt: pads 2,5,7 -> "ABC"
    set_ct(0, 8'd3, 8'h43, 8'h47, 8'h44);
    push_basic(0);
    start(0);
    wait_done();
    chk("basic_s2", int'(smem[0][2]), 3);
    chk("basic_s3", int'(smem[0][3]), 5);
    chk("basic_s5", int'(smem[0][5]), 2);
    chk("basic_s1", int'(smem[0][1]), 1);

    // Early abort on byte 2 (pt=0x00)
    init_s();
    set_ct(0, 8'd3, 8'h43, 8'h05, 8'h44);
    exp_w(0, 8'd0, 8'd3); exp_w(0, 8'd1, 8'h41); exp_w(0, 8'd2, 8'h00);
    exp_end(0, 1'b0, 22);
    start(0);
    wait_done();
    chk("abort_s2", int'(smem[0][2]), 3);
    chk("abort_s3", int'(smem[0][3]), 2);

    // Same message without early abort decrypts the full length
    init_s();
    set_ct(1, 8'd3, 8'h43, 8'h05, 8'h44);
    exp_w(1, 8'd0, 8'd3); exp_w(1, 8'd1, 8'h41); exp_w(1, 8'd2, 8'h00); exp_w(1, 8'd3, 8'h43);
    exp_end(1, 1'b0, 31);
    start(1);
    wait_done();

    // Zero length leaves S untouched
    init_s();
    set_ct(0, 8'd0, 8'h43, 8'h47, 8'h44);
    exp_w(0, 8'd0, 8'd0);
    exp_end(0, 1'b1, 4);
    start(0);
    wait_done();
    chk("zero_s1", int'(smem[0][1]), 1);
    chk("zero_s2", int'(smem[0][2]), 2);

    // en held high: exactly one run per rdy cycle, back-to-back restart
    exp_w(0, 8'd0, 8'd0); exp_end(0, 1'b1, 4);
    exp_w(0, 8'd0, 8'd0); exp_end(0, 1'b1, 4);
    @(negedge clk); en[0] = 1'b1;
    @(posedge clk);
    t = 0;
    do begin
      @(negedge clk); t++;
    end while (!rdy[0] && t < 50);
    chk("proto_rdy_seen", int'(rdy[0]), 1);
    @(posedge clk); #1;
    en[0] = 1'b0;
    chk("proto_restart", int'(rdy[0]), 0);
    wait_done();

    // Reset during WR_SJ of byte 2
    init_s();
    set_ct(0, 8'd3, 8'h43, 8'h47, 8'h44);
    push_basic(0);
    start(0);
    repeat (17) @(posedge clk);
    #1;
    chk("midrun_s_wren", int'(s_wren[0]), 1);
    chk("midrun_s_addr", int'(s_addr[0]), 3);
    chk("midrun_s_wrdata", int'(s_wrdata[0]), 2);
    exp_pt.delete();
    exp_done.delete();
    rst = 1'b1;
    #1;
    chk("rst_rdy", int'(rdy[0]), 1);
    chk("rst_valid", int'(valid[0]), 1);
    chk("rst_s_wren", int'(s_wren[0]), 0);
    chk("rst_pt_wren", int'(pt_wren[0]), 0);
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    chk("rst_partial_s3", int'(smem[0][3]), 3);
    init_s();
    push_basic(0);
    start(0);
    wait_done();
    chk("rerun_s2", int'(smem[0][2]), 3);
    chk("rerun_s3", int'(smem[0][3]), 5);
    chk("rerun_s5", int'(smem[0][5]), 2);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
